// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory command controller: default widths,
// command encodings and the controller state enumeration.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_RSP,
        ST_WR,
        ST_CP_RD,
        ST_CP_WR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Command controller in front of a registered-read RAM: single-byte READ/WRITE
// and a byte-serial forward COPY driven by a down-counting remaining-length timer.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | ready for a command; all RAM strobes low
// ST_RD     | READ: MemRead at latched address
// ST_RD_RSP | READ: mem_out valid, captured into resp_rdata, resp pulse
// ST_WR     | WRITE: MemWrite with latched address and data
// ST_CP_RD  | COPY: read current source byte
// ST_CP_WR  | COPY: write that byte to destination, advance pointers
// ST_DONE   | completion pulse for WRITE, COPY and reserved op
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_out
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        wdat_d     = wdat_q;
        rdata_d    = rdata_q;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        addr       = '0;
        wdata      = '0;
        resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    src_d  = req_addr;
                    dst_d  = req_dst;
                    cnt_d  = req_len;
                    wdat_d = req_wdata;
                    case (op_e'(req_op))
                        OP_READ:  state_d = ST_RD;
                        OP_WRITE: state_d = ST_WR;
                        OP_COPY:  state_d = (req_len == '0) ? ST_DONE : ST_CP_RD;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_RD: begin
                MemRead = 1'b1;
                addr    = src_q;
                state_d = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                resp_valid = 1'b1;
                rdata_d    = mem_out;
                state_d    = ST_IDLE;
            end
            ST_WR: begin
                MemWrite = 1'b1;
                addr     = src_q;
                wdata    = wdat_q;
                state_d  = ST_DONE;
            end
            ST_CP_RD: begin
                MemRead = 1'b1;
                addr    = src_q;
                state_d = ST_CP_WR;
            end
            ST_CP_WR: begin
                MemWrite = 1'b1;
                addr     = dst_q;
                wdata    = mem_out;
                src_d    = src_q + ADDR_W'(1);
                dst_d    = dst_q + ADDR_W'(1);
                cnt_d    = cnt_q - ADDR_W'(1);
                state_d  = (cnt_q == ADDR_W'(1)) ? ST_DONE : ST_CP_RD;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset wins at once: no strobe or pulse may escape on the reset edge.
        if (rst) begin
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            addr       = '0;
            wdata      = '0;
            resp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 256-byte registered-read RAM.
module tb_mem_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_dst;
    logic [7:0] req_len;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       busy;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mem_out;

    logic [7:0] ram [256];

    int tests;
    int fails;
    int both_cnt;

    mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .wdata      (wdata),
        .mem_out    (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MemWrite) ram[addr] <= wdata;
        if (MemRead) mem_out <= ram[addr];
    end

    initial both_cnt = 0;
    always @(negedge clk) begin
        if (MemRead && MemWrite) both_cnt = both_cnt + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one command, then scrambles the request inputs (and optionally keeps
    // req_valid high) to prove latching and that nothing else is accepted while busy.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] w, input bit hold,
                           output int lat, output int strobes, output int busy_lo,
                           output int ready_hi, output logic [7:0] rdata);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_dst   = d;
        req_len   = l;
        req_wdata = w;
        @(posedge clk);
        @(negedge clk);
        req_valid = hold;
        req_op    = 2'b00;
        req_addr  = ~a;
        req_dst   = ~d;
        req_len   = ~l;
        req_wdata = ~w;
        lat = 0;
        strobes = 0;
        busy_lo = 0;
        ready_hi = 0;
        for (int c = 1; c <= 200; c++) begin
            if (MemRead || MemWrite) strobes++;
            if (!busy) busy_lo++;
            if (req_ready) ready_hi++;
            if (resp_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rdata = resp_rdata;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] l;
        logic [7:0] w;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, strobes, busy_lo, ready_hi;
        int saw_resp;
        logic [7:0] rdata;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_addr = 8'h00;
        req_dst = 8'h00;
        req_len = 8'h00;
        req_wdata = 8'h00;

        // op, addr, dst, len, wdata, held rdata after completion, latency, strobe cycles
        vecs.push_back('{2'b01, 8'h10, 8'h00, 8'h00, 8'hA5, 8'h00, 2, 1});
        vecs.push_back('{2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h20, 8'h00, 8'h00, 8'h01, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h21, 8'h00, 8'h00, 8'h02, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h22, 8'h00, 8'h00, 8'h03, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h23, 8'h00, 8'h00, 8'h04, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'hFE, 8'h00, 8'h00, 8'h5A, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'hFF, 8'h00, 8'h00, 8'h6B, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h00, 8'h00, 8'h00, 8'h7C, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h30, 8'h00, 8'h00, 8'h11, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h31, 8'h00, 8'h00, 8'h22, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h32, 8'h00, 8'h00, 8'h33, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h42, 8'h00, 8'h00, 8'hEE, 8'hA5, 2, 1});
        vecs.push_back('{2'b01, 8'h50, 8'h00, 8'h00, 8'h99, 8'hA5, 2, 1});
        vecs.push_back('{2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h6B, 2, 1});
        vecs.push_back('{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7C, 2, 1});
        vecs.push_back('{2'b11, 8'h10, 8'h00, 8'h00, 8'h00, 8'h7C, 1, 0});
        vecs.push_back('{2'b10, 8'h20, 8'h90, 8'h00, 8'h00, 8'h7C, 1, 0});

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_rdata", int'(resp_rdata), 0);
        check("rst_memread", int'(MemRead), 0);
        check("rst_memwrite", int'(MemWrite), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_req_ready_low", int'(req_ready), 0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", int'(req_ready), 1);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].l, vecs[i].w, 1'b0,
                    lat, strobes, busy_lo, ready_hi, rdata);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_strobes", i), strobes, vecs[i].exp_strobes);
            check($sformatf("vec%0d_busy", i), busy_lo, 0);
            check($sformatf("vec%0d_rdata", i), int'(rdata), int'(vecs[i].exp_rdata));
        end
        check("len0_no_write", int'(ram[8'h90]), 0);

        // 4-byte copy with req_valid held high throughout
        run_cmd(2'b10, 8'h20, 8'h80, 8'h04, 8'h00, 1'b1, lat, strobes, busy_lo, ready_hi, rdata);
        check("copy4_latency", lat, 9);
        check("copy4_strobes", strobes, 8);
        check("copy4_busy", busy_lo, 0);
        check("copy4_no_accept_busy", ready_hi, 0);
        check("copy4_idle_after", int'(busy), 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("copy4_byte%0d", k), int'(ram[8'h80 + k]), k + 1);

        run_cmd(2'b10, 8'hFE, 8'h01, 8'h03, 8'h00, 1'b0, lat, strobes, busy_lo, ready_hi, rdata);
        check("wrap_latency", lat, 7);
        check("wrap_byte0", int'(ram[8'h01]), 8'h5A);
        check("wrap_byte1", int'(ram[8'h02]), 8'h6B);
        check("wrap_byte2", int'(ram[8'h03]), 8'h7C);

        run_cmd(2'b10, 8'h50, 8'h51, 8'h03, 8'h00, 1'b0, lat, strobes, busy_lo, ready_hi, rdata);
        check("overlap_byte0", int'(ram[8'h51]), 8'h99);
        check("overlap_byte2", int'(ram[8'h53]), 8'h99);

        // Reset during byte 2 (third CP_RD) of an 8-byte copy
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 8'h30;
        req_dst   = 8'h40;
        req_len   = 8'h08;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        saw_resp = 0;
        for (int c = 1; c < 5; c++) begin
            if (resp_valid) saw_resp++;
            @(negedge clk);
        end
        check("rst_copy_in_byte2_read", int'(MemRead), 1);
        rst = 1'b1;
        #1;
        check("rst_gates_memread", int'(MemRead), 0);
        check("rst_gates_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_copy_idle", int'(busy), 0);
        check("rst_copy_ready", int'(req_ready), 1);
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) saw_resp++;
            @(negedge clk);
        end
        check("rst_copy_no_resp", saw_resp, 0);
        check("rst_copy_byte0", int'(ram[8'h40]), 8'h11);
        check("rst_copy_byte1", int'(ram[8'h41]), 8'h22);
        check("rst_copy_byte2_untouched", int'(ram[8'h42]), 8'hEE);

        check("rw_never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width in bits (256-byte space).
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a command.
REQ-006 SHALL have port req_ready  output  1  controller accepts a command this cycle.
REQ-007 SHALL have port req_op  input  2  command: 00 READ, 01 WRITE, 10 COPY, 11 reserved.
REQ-008 SHALL have port req_addr  input  ADDR_W  READ/WRITE address; COPY source base.
REQ-009 SHALL have port req_dst  input  ADDR_W  COPY destination base.
REQ-010 SHALL have port req_len  input  ADDR_W  COPY byte count.
REQ-011 SHALL have port req_wdata  input  DATA_W  WRITE data.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_W  READ result, registered, held until the next READ completes.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have ports MemRead, MemWrite (output 1 each), addr (output ADDR_W), wdata (output DATA_W), mem_out (input DATA_W), wired to the 256-byte RAM.

Function
REQ-016 SHALL treat the RAM as: registered read, data valid on mem_out the cycle after MemRead is high; write on the edge where MemWrite is high; never drive MemRead and MemWrite high together.
REQ-017 SHALL implement states IDLE, RD, RD_RSP, WR, CP_RD, CP_WR, DONE.
REQ-018 SHALL drive req_ready = 1 only in IDLE; a command is accepted on an edge where req_valid && req_ready.
REQ-019 SHALL latch req_addr, req_dst, req_len and req_wdata on acceptance; later changes to the inputs are ignored.
REQ-020 READ: IDLE->RD (MemRead=1, addr=latched addr)->RD_RSP (resp_rdata<=mem_out, resp_valid=1)->IDLE; resp_valid SHALL be high on the 2nd cycle after the accepting edge.
REQ-021 WRITE: IDLE->WR (MemWrite=1, addr, wdata)->DONE (resp_valid=1)->IDLE.
REQ-022 COPY: per byte, CP_RD (MemRead=1, addr=src) then CP_WR (MemWrite=1, addr=dst, wdata=mem_out); 2 cycles/byte; after the last CP_WR ->DONE (resp_valid=1)->IDLE.
REQ-023 COPY src/dst SHALL increment modulo 2^ADDR_W (0xFF wraps to 0x00); the remaining count SHALL decrement once per CP_WR.
REQ-024 COPY with req_len=0 SHALL go IDLE->DONE directly, with no RAM strobes.
REQ-025 Overlapping COPY SHALL proceed strictly forward byte-by-byte; dst=src+1 therefore replicates the source byte (defined behaviour).
REQ-026 req_op=11 SHALL be accepted and go to DONE with no RAM strobes.
REQ-027 MemRead, MemWrite and resp_valid SHALL be 0 in every state other than those listed above.
REQ-028 addr and wdata SHALL be 0 in IDLE and DONE.

Reset
REQ-029 On rst: state<=IDLE; resp_valid, resp_rdata, MemRead, MemWrite, addr, wdata, busy <= 0; internal counters <= 0.
REQ-030 rst mid-COPY SHALL abandon the copy with no resp_valid; bytes already written stay written; rst has priority over every other event.
REQ-031 req_ready SHALL be 0 while rst is high.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the op encodings, the state enumeration, and ADDR_W/DATA_W defaults.
REQ-033 mem_ctrl SHALL be a single module with no sub-modules; the RAM is instantiated beside it at the next level up.

Verification
REQ-034 The bench SHALL WRITE 0xA5 to 0x10, then READ 0x10 -> resp_rdata=0xA5, resp_valid 2 cycles after acceptance.
REQ-035 The bench SHALL preload 0x20..0x23 with 1,2,3,4 and COPY src=0x20 dst=0x80 len=4 -> 0x80..0x83 = 1,2,3,4, resp_valid 9 cycles after acceptance, busy high throughout.
REQ-036 The bench SHALL COPY src=0xFE dst=0x01 len=3 -> bytes 0xFE,0xFF,0x00 land at 0x01,0x02,0x03 (wrap).
REQ-037 The bench SHALL COPY len=0 -> resp_valid on the cycle after acceptance, MemRead/MemWrite never high.
REQ-038 The bench SHALL assert rst for 1 cycle during byte 2 of a len=8 COPY -> next cycle IDLE, req_ready=1, no resp_valid, only bytes 0-1 copied.
REQ-039 The bench SHALL hold req_valid during busy -> no second acceptance until IDLE, and MemRead&&MemWrite is never observed high.
